icu_tag_bist_ctrl: RTL and testbench

- March C- BIST engine that drives the RAM BIST port of the ICU tag array (256 words x 46 bits: way A tag+parity, way B tag+parity).
- Issues one SRAM access per cycle on the bist_* signals, compares the returned read data against the expected background, and reports pass/fail with first-failure diagnostics.
- Sits beside the tag array wrapper and is started by the chip-level test controller.

---
 rtl/icu_tag_bist_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_icu_tag_bist_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icu_tag_bist_ctrl.sv
// March C- BIST engine for the ICU tag array: one SRAM op per cycle on the bist_* port,
// read data checked against the element background through an RD_LAT-deep compare pipe.
module icu_tag_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 46,
    parameter int RD_LAT = 1
) (
    input  logic              CB,
    input  logic              rst_n,
    input  logic              bist_start,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [7:0]        fail_count,
    output logic              bist_mode,
    output logic              bist_ce_n,
    output logic              bist_we_n,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [DATA_W-1:0] bist_wr_data,
    input  logic [DATA_W-1:0] bist_rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic                start_q, start_prev_q;
    logic [2:0]          elem_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_op_q;
    logic [1:0]          drain_cnt_q;
    logic                mode_q, ce_n_q, we_n_q, done_q, fail_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [ADDR_W-1:0]   fail_addr_q;
    logic [2:0]          fail_elem_q;
    logic [7:0]          fail_count_q;

    logic                pv_q    [RD_LAT];
    logic                pexp_q  [RD_LAT];
    logic [ADDR_W-1:0]   paddr_q [RD_LAT];
    logic [2:0]          pelem_q [RD_LAT];

    logic                up, at_last, run_end, nxt_rd, nxt_wval, miscmp;
    logic [2:0]          nxt_elem;
    logic [ADDR_W-1:0]   nxt_addr;

    // Successor of the op currently on the port; elements 0-2 walk up, 3-5 walk down.
    always_comb begin
        up       = (elem_q <= 3'd2);
        at_last  = up ? (addr_q == {ADDR_W{1'b1}}) : (addr_q == '0);
        nxt_elem = elem_q;
        nxt_addr = addr_q;
        nxt_rd   = rd_op_q;
        run_end  = 1'b0;
        case (elem_q)
            3'd0: begin
                if (at_last) begin
                    nxt_elem = 3'd1;
                    nxt_addr = '0;
                    nxt_rd   = 1'b1;
                end else begin
                    nxt_addr = addr_q + 1'b1;
                    nxt_rd   = 1'b0;
                end
            end
            3'd5: begin
                if (at_last) run_end = 1'b1;
                else begin
                    nxt_addr = addr_q - 1'b1;
                    nxt_rd   = 1'b1;
                end
            end
            default: begin
                if (rd_op_q) begin
                    nxt_rd = 1'b0;
                end else if (at_last) begin
                    nxt_elem = elem_q + 3'd1;
                    nxt_addr = (elem_q + 3'd1 <= 3'd2) ? '0 : {ADDR_W{1'b1}};
                    nxt_rd   = 1'b1;
                end else begin
                    nxt_addr = up ? addr_q + 1'b1 : addr_q - 1'b1;
                    nxt_rd   = 1'b1;
                end
            end
        endcase
        nxt_wval = (nxt_elem == 3'd1) || (nxt_elem == 3'd3);
        miscmp   = pv_q[RD_LAT-1] && (bist_rd_data != {DATA_W{pexp_q[RD_LAT-1]}});
    end

    always_ff @(posedge CB or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            elem_q       <= '0;
            addr_q       <= '0;
            rd_op_q      <= 1'b0;
            drain_cnt_q  <= '0;
            mode_q       <= 1'b0;
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= '0;
            fail_count_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i]    <= 1'b0;
                pexp_q[i]  <= 1'b0;
                paddr_q[i] <= '0;
                pelem_q[i] <= '0;
            end
        end else begin
            start_q      <= bist_start;
            start_prev_q <= start_q;

            pv_q[0]    <= !ce_n_q && we_n_q;
            pexp_q[0]  <= (elem_q == 3'd2) || (elem_q == 3'd4);
            paddr_q[0] <= addr_q;
            pelem_q[0] <= elem_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]    <= pv_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
                paddr_q[i] <= paddr_q[i-1];
                pelem_q[i] <= pelem_q[i-1];
            end

            if (miscmp) begin
                fail_q <= 1'b1;
                if (fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
                if (!fail_q) begin
                    fail_addr_q <= paddr_q[RD_LAT-1];
                    fail_elem_q <= pelem_q[RD_LAT-1];
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start_q && !start_prev_q) begin
                        state_q      <= S_RUN;
                        mode_q       <= 1'b1;
                        ce_n_q       <= 1'b0;
                        we_n_q       <= 1'b0;
                        addr_q       <= '0;
                        elem_q       <= '0;
                        rd_op_q      <= 1'b0;
                        wr_data_q    <= '0;
                        done_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        fail_addr_q  <= '0;
                        fail_elem_q  <= '0;
                        fail_count_q <= '0;
                    end
                end
                S_RUN: begin
                    if (run_end) begin
                        state_q     <= S_DRAIN;
                        ce_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                        wr_data_q   <= '0;
                        drain_cnt_q <= '0;
                    end else begin
                        elem_q    <= nxt_elem;
                        addr_q    <= nxt_addr;
                        rd_op_q   <= nxt_rd;
                        ce_n_q    <= 1'b0;
                        we_n_q    <= nxt_rd;
                        wr_data_q <= nxt_rd ? '0 : {DATA_W{nxt_wval}};
                    end
                end
                S_DRAIN: begin
                    // The last read's compare lands on the same edge that raises done.
                    if (drain_cnt_q == 2'(RD_LAT - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        mode_q  <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bist_done    = done_q;
    assign bist_fail    = fail_q;
    assign fail_addr    = fail_addr_q;
    assign fail_elem    = fail_elem_q;
    assign fail_count   = fail_count_q;
    assign bist_mode    = mode_q;
    assign bist_ce_n    = ce_n_q;
    assign bist_we_n    = we_n_q;
    assign bist_addr    = addr_q;
    assign bist_wr_data = wr_data_q;

endmodule

// File: tb/tb_icu_tag_bist_ctrl.sv
// Directed bench for icu_tag_bist_ctrl: RD_LAT=1 and RD_LAT=3 instances, each with an SRAM
// model that can inject stuck-at faults on reads.
module tb_icu_tag_bist_ctrl;

    logic CB = 1'b0;
    logic rst_n = 1'b0;
    always #5 CB = ~CB;

    logic        st1, st3;
    logic        u1_done, u1_fail, u1_mode, u1_ce_n, u1_we_n;
    logic [7:0]  u1_faddr, u1_fcnt, u1_addr;
    logic [2:0]  u1_felem;
    logic [45:0] u1_wd, u1_rd;
    logic        u3_done, u3_fail, u3_mode, u3_ce_n, u3_we_n;
    logic [7:0]  u3_faddr, u3_fcnt, u3_addr;
    logic [2:0]  u3_felem;
    logic [45:0] u3_wd, u3_rd;

    icu_tag_bist_ctrl #(.ADDR_W(8), .DATA_W(46), .RD_LAT(1)) u1 (
        .CB(CB), .rst_n(rst_n), .bist_start(st1), .bist_done(u1_done), .bist_fail(u1_fail),
        .fail_addr(u1_faddr), .fail_elem(u1_felem), .fail_count(u1_fcnt), .bist_mode(u1_mode),
        .bist_ce_n(u1_ce_n), .bist_we_n(u1_we_n), .bist_addr(u1_addr), .bist_wr_data(u1_wd),
        .bist_rd_data(u1_rd));

    icu_tag_bist_ctrl #(.ADDR_W(8), .DATA_W(46), .RD_LAT(3)) u3 (
        .CB(CB), .rst_n(rst_n), .bist_start(st3), .bist_done(u3_done), .bist_fail(u3_fail),
        .fail_addr(u3_faddr), .fail_elem(u3_felem), .fail_count(u3_fcnt), .bist_mode(u3_mode),
        .bist_ce_n(u3_ce_n), .bist_we_n(u3_we_n), .bist_addr(u3_addr), .bist_wr_data(u3_wd),
        .bist_rd_data(u3_rd));

    // SRAM models; a zero mask disables the corresponding fault.
    logic [45:0] mem1 [256];
    logic [45:0] mem3 [256];
    logic [7:0]  sa0_addr = 8'h00, sa1_addr = 8'h00;
    logic [45:0] sa0_mask = '0, sa1_mask = '0;
    logic [45:0] p3a, p3b;

    function automatic logic [45:0] flt(input logic [45:0] d, input logic [7:0] a);
        logic [45:0] r;
        r = d;
        if (a == sa0_addr) r = r & ~sa0_mask;
        if (a == sa1_addr) r = r | sa1_mask;
        return r;
    endfunction

    always @(posedge CB) begin
        if (!u1_ce_n) begin
            if (!u1_we_n) mem1[u1_addr] <= u1_wd;
            else          u1_rd <= flt(mem1[u1_addr], u1_addr);
        end
        if (!u3_ce_n) begin
            if (!u3_we_n) mem3[u3_addr] <= u3_wd;
            else          p3a <= flt(mem3[u3_addr], u3_addr);
        end
        p3b   <= p3a;
        u3_rd <= p3b;
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int which);
        @(negedge CB);
        if (which == 3) st3 = 1'b1; else st1 = 1'b1;
        @(negedge CB);
        if (which == 3) st3 = 1'b0; else st1 = 1'b0;
    endtask

    // Waits for launch, counts cycles from it (launch cycle = 1) and checks the done cycle.
    task automatic track_run(input int which, input int exp_done, input int abort_cyc,
                             input bit ops_en);
        int   cyc;
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge CB); #1;
            got = (which == 3) ? u3_mode : u1_mode;
        end
        if (!got) begin
            chk("launch_seen", 64'd0, 64'd1);
            return;
        end
        chk("launch_clr_done", (which == 3) ? u3_done : u1_done, 64'd0);
        chk("launch_clr_fail", (which == 3) ? u3_fail : u1_fail, 64'd0);
        chk("launch_clr_cnt",  (which == 3) ? u3_fcnt : u1_fcnt, 64'd0);
        cyc = 1;
        while (cyc < 3000) begin
            if (ops_en) begin
                if (cyc == 1) begin
                    chk("c1_ce_n", u1_ce_n, 64'd0);
                    chk("c1_we_n", u1_we_n, 64'd0);
                    chk("c1_addr", u1_addr, 64'h00);
                    chk("c1_data", u1_wd, 64'd0);
                end
                if (cyc == 257) begin
                    chk("c257_ce_n", u1_ce_n, 64'd0);
                    chk("c257_we_n", u1_we_n, 64'd1);
                    chk("c257_addr", u1_addr, 64'h00);
                    chk("c257_data", u1_wd, 64'd0);
                end
                if (cyc == 258) begin
                    chk("c258_we_n", u1_we_n, 64'd0);
                    chk("c258_addr", u1_addr, 64'h00);
                    chk("c258_data", u1_wd, 64'h3FFF_FFFF_FFFF);
                end
                if (cyc == 1281) begin
                    chk("c1281_we_n", u1_we_n, 64'd1);
                    chk("c1281_addr", u1_addr, 64'hFF);
                end
                if (cyc == 2560) begin
                    chk("c2560_rd_addr", {u1_ce_n, u1_we_n, u1_addr}, {2'b01, 8'h00});
                end
                if (cyc == 2561) begin
                    chk("c2561_ce_n", u1_ce_n, 64'd1);
                    chk("c2561_mode", u1_mode, 64'd1);
                end
            end
            if (cyc == abort_cyc) begin
                chk("pre_abort_cnt", u1_fcnt, 64'd1);
                #2 rst_n = 1'b0;
                #1;
                chk("abort_ce_n", u1_ce_n, 64'd1);
                chk("abort_mode", u1_mode, 64'd0);
                chk("abort_results", {u1_done, u1_fail, u1_faddr, u1_felem, u1_fcnt}, 64'd0);
                return;
            end
            if ((which == 3) ? u3_done : u1_done) break;
            @(posedge CB); #1;
            cyc++;
        end
        chk("done_cycle", cyc, exp_done);
    endtask

    task automatic check_res(input int which, input logic fl, input logic [7:0] fa,
                             input logic [2:0] fe, input logic [7:0] fc);
        if (which == 3) begin
            chk("res_fail", u3_fail, fl);
            chk("res_addr", u3_faddr, fa);
            chk("res_elem", u3_felem, fe);
            chk("res_cnt",  u3_fcnt, fc);
        end else begin
            chk("res_fail", u1_fail, fl);
            chk("res_addr", u1_faddr, fa);
            chk("res_elem", u1_felem, fe);
            chk("res_cnt",  u1_fcnt, fc);
        end
    endtask

    initial begin
        st1 = 1'b0;
        st3 = 1'b0;
        repeat (3) @(posedge CB);
        #1;
        chk("rst_outs", {u1_done, u1_fail, u1_faddr, u1_felem, u1_fcnt, u1_mode}, 64'd0);
        chk("rst_ce_we", {u1_ce_n, u1_we_n}, 64'd3);
        chk("rst_addr_data", {u1_addr, u1_wd}, 64'd0);
        chk("rst3_ce_mode", {u3_ce_n, u3_mode, u3_done}, 64'b100);
        @(negedge CB);
        rst_n = 1'b1;

        // Clean pass with op-sequence checks.
        pulse_start(1);
        track_run(1, 2562, 0, 1'b1);
        check_res(1, 1'b0, 8'h00, 3'd0, 8'd0);
        chk("mode_after_done", u1_mode, 64'd0);
        repeat (5) @(posedge CB);

        // Stuck-at-0 on bit 17 at 0x2A.
        sa0_addr = 8'h2A;
        sa0_mask = 46'h1 << 17;
        pulse_start(1);
        track_run(1, 2562, 0, 1'b0);
        check_res(1, 1'b1, 8'h2A, 3'd2, 8'd2);
        repeat (5) @(posedge CB);

        // Stuck-at-1 at 0x10 plus stuck-at-0 at 0x05, start held high through done.
        sa1_addr = 8'h10;
        sa1_mask = 46'h1 << 3;
        sa0_addr = 8'h05;
        sa0_mask = 46'h1 << 40;
        @(negedge CB);
        st1 = 1'b1;
        track_run(1, 2562, 0, 1'b0);
        check_res(1, 1'b1, 8'h10, 3'd1, 8'd5);
        repeat (100) @(posedge CB);
        #1;
        chk("held_no_rerun_mode", u1_mode, 64'd0);
        chk("held_done_kept", u1_done, 64'd1);
        chk("held_cnt_kept", u1_fcnt, 64'd5);
        @(negedge CB);
        st1 = 1'b0;
        sa0_mask = '0;
        sa1_mask = '0;
        repeat (3) @(negedge CB);
        st1 = 1'b1;
        track_run(1, 2562, 0, 1'b0);
        check_res(1, 1'b0, 8'h00, 3'd0, 8'd0);
        @(negedge CB);
        st1 = 1'b0;
        repeat (5) @(posedge CB);

        // Reset mid-run, then a clean run.
        sa1_addr = 8'h10;
        sa1_mask = 46'h1 << 3;
        pulse_start(1);
        track_run(1, 2562, 1000, 1'b0);
        @(negedge CB);
        rst_n = 1'b1;
        sa1_mask = '0;
        repeat (3) @(posedge CB);
        pulse_start(1);
        track_run(1, 2562, 0, 1'b0);
        check_res(1, 1'b0, 8'h00, 3'd0, 8'd0);
        repeat (5) @(posedge CB);

        // RD_LAT=3 instance: faulty run then clean rerun.
        sa0_addr = 8'h2A;
        sa0_mask = 46'h1 << 17;
        pulse_start(3);
        track_run(3, 2564, 0, 1'b0);
        check_res(3, 1'b1, 8'h2A, 3'd2, 8'd2);
        sa0_mask = '0;
        repeat (5) @(posedge CB);
        pulse_start(3);
        track_run(3, 2564, 0, 1'b0);
        check_res(3, 1'b0, 8'h00, 3'd0, 8'd0);
        chk("u3_mode_after", u3_mode, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
